// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// segment patterns ({a,b,c,d,e,f,g}, active-high, bit 6 = a), the
// scan FSM state type and the BCD-to-segment decode function.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1110011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // GUARD: all digits dark at the start of a slot; ON: selected digit lit.
  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } scan_state_e;

  // Codes 10..15 are not valid BCD and show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to 7-segment decoder; one instance sits on the
// digit currently selected by the scanner.
module bcd_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = bcd_to_seg(bcd_i);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed NUM_DIGITS-digit 7-segment driver.
// Each digit owns a slot of REFRESH_DIV cycles; the first GUARD_CYC cycles of
// every slot are dark to suppress ghosting. New digit values arrive through a
// valid/ready handshake into a pending buffer and are copied to the display
// register only when the scan wraps to digit 0, so a frame never mixes values.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros (digit 0
// always shows; dash codes count as nonzero). Scan timing is the same either way.
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_VAL = CNT_W'(GUARD_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  scan_state_e           state_q, state_d;

  // Data path state
  logic [DATA_W-1:0]     display_q, display_d;
  logic [DATA_W-1:0]     pending_q;
  logic                  ready_q, ready_d;

  // Registered outputs
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  tick_q;

  logic                  slot_end;
  logic                  frame_end;
  logic                  accept;
  logic [3:0]            digit_cur;
  logic [6:0]            seg_dec;
  logic                  blank;

  assign slot_end  = (cnt_q == LAST_CNT);
  assign frame_end = slot_end && (idx_q == LAST_IDX);
  assign accept    = in_valid && ready_q;

  // Slot counter and digit index advance; FSM next state from the slot position.
  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    if (slot_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    case (state_q)
      GUARD:   if (cnt_d >= GUARD_VAL) state_d = ON;
      ON:      if (cnt_d < GUARD_VAL)  state_d = GUARD;
      default: state_d = GUARD;
    endcase
  end

  // Scan state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= GUARD;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Handshake and frame-boundary update of the display register.
  // An accept and a pending copy cannot coincide: accept needs pending empty.
  always_comb begin
    display_d = display_q;
    ready_d   = ready_q;
    if (accept) begin
      ready_d = 1'b0;
    end else if (frame_end && !ready_q) begin
      display_d = pending_q;
      ready_d   = 1'b1;
    end
  end

  // Display register and pending-empty flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      display_q <= '0;
      ready_q   <= 1'b1;
    end else begin
      display_q <= display_d;
      ready_q   <= ready_d;
    end
  end

  // Pending data buffer; its contents only matter while ready_q is low.
  // NOTE: pure data storage is left without reset; the qualifying flag carries the reset state.
  always_ff @(posedge clk) begin
    if (accept) begin
      pending_q <= digits_in;
    end
  end

  // Select the scanned digit, build the one-hot enable and the blanking flag.
  always_comb begin
    digit_cur = 4'd0;
    en_d      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        digit_cur = display_q[4*k +: 4];
        en_d[k]   = (state_q == ON);
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every digit above it are zero, except digit 0.
    blank = (idx_q != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((IDX_W'(k) >= idx_q) && (display_q[4*k +: 4] != 4'd0)) begin
        blank = 1'b0;
      end
    end
`else
    blank = 1'b0;
`endif
    seg_d = ((state_q == ON) && !blank) ? seg_dec : SEG_OFF;
  end

  bcd_seg_decode u_decode (
    .bcd_i (digit_cur),
    .seg_o (seg_dec)
  );

  // Output registers; they lag the scan state by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q  <= SEG_OFF;
      en_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      en_q   <= en_d;
      tick_q <= frame_end;
    end
  end

  assign seg_out    = seg_q;
  assign digit_en   = en_q;
  assign frame_tick = tick_q;
  assign in_ready   = ready_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (4 digits, 8-cycle slots,
// 2 guard cycles). A frame-level reference model predicts every output cycle
// and pushes it into a scoreboard; a monitor on the falling edge pops and compares.
module tb_seven_segment_scanner;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GC    = 2;
  localparam int FRAME = ND * RD;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [4*ND-1:0]  digits_in;
  logic [6:0]       seg_out;
  logic [ND-1:0]    digit_en;
  logic             frame_tick;

  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] en;
    logic          tick;
    logic          ready;
  } obs_t;

  obs_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: position in the scan since reset, shown and pending values.
  int              p       = 0;
  logic [4*ND-1:0] m_disp  = '0;
  logic [4*ND-1:0] m_pend  = '0;
  logic            m_ready = 1'b1;
  obs_t            exp_o;
  obs_t            got_o;
  obs_t            want_o;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b0000001, 7'b0000001,
    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001
  };

  seven_segment_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYC   (GC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .digits_in  (digits_in),
    .seg_out    (seg_out),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, want, $time);
    end
  endtask

  // What the display shows at scan position pos for a given display value.
  function automatic obs_t expect_at(input int pos, input logic [4*ND-1:0] disp);
    int         k;
    int         off;
    logic [3:0] code;
    obs_t       o;
    k    = (pos / RD) % ND;
    off  = pos % RD;
    code = disp[4*k +: 4];
    o    = '0;
    o.tick = ((pos % FRAME) == FRAME - 1);
    if (off >= GC) begin
      o.en  = ND'(1 << k);
      o.seg = seg_tab[code];
`ifdef LEADING_ZERO_BLANK_EN
      if ((k > 0) && ((disp >> (4*k)) == 0)) o.seg = 7'b0;
`endif
    end
    return o;
  endfunction

  // Reference model: one prediction per clock, then handshake/frame bookkeeping.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p       = 0;
      m_disp  = '0;
      m_ready = 1'b1;
      sb.delete();
    end else begin
      exp_o = expect_at(p, m_disp);
      if (in_valid && m_ready) begin
        m_pend  = digits_in;
        m_ready = 1'b0;
      end else if (exp_o.tick && !m_ready) begin
        m_disp  = m_pend;
        m_ready = 1'b1;
      end
      exp_o.ready = m_ready;
      sb.push_back(exp_o);
      p++;
    end
  end

  // Monitor: compare DUT outputs with the oldest prediction, away from the active edge.
  always @(negedge clk) begin
    if (reset_n && (sb.size() > 0)) begin
      want_o = sb.pop_front();
      got_o  = {seg_out, digit_en, frame_tick, in_ready};
      check("scan_cycle", 32'(got_o), 32'(want_o));
    end
  end

  // One-cycle valid pulse; accepted only if the DUT is ready on that edge.
  task automatic pulse(input logic [4*ND-1:0] data);
    @(negedge clk);
    in_valid  = 1'b1;
    digits_in = data;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Wait (bounded) for an empty pending buffer.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [4*ND-1:0] data);
    wait_ready();
    pulse(data);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    digits_in = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Power-up scan, then reset asserted between edges at cycle 13.
    repeat (13) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({seg_out, digit_en, frame_tick, in_ready}), 32'h001);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    // Mid-frame load, then a second offer while busy that must be dropped.
    repeat (5) @(negedge clk);
    pulse(16'h4321);
    check("ready_low_after_accept", 32'(in_ready), 32'd0);
    pulse(16'h9999);
    wait_ready();
    repeat (FRAME + 4) @(negedge clk);

    // Dash codes and a zero digit.
    send(16'hFA07);
    wait_ready();
    repeat (FRAME + 4) @(negedge clk);

    // Leading zeros (blanked only in the LEADING_ZERO_BLANK_EN build).
    send(16'h0050);
    wait_ready();
    repeat (FRAME + 4) @(negedge clk);

    // Reset mid-frame while something is displayed: everything clears.
    repeat (11) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_loaded", 32'({seg_out, digit_en, frame_tick, in_ready}), 32'h001);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (FRAME + 3) @(negedge clk);

    // Randomized offers: some land on an empty buffer, most hit a busy one.
    repeat (1500) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) digits_in = 16'($urandom_range(0, 15) << (4 * $urandom_range(0, 3)));
      else                           digits_in = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
